// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported word RAM.
// Data accesses take priority over fetches. Byte lanes are steered for stores,
// and load data is extracted from the addressed lanes. Misaligned data accesses
// and RAM timeouts are reported with one-cycle pulses.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        imem_ren,
  input  logic [31:0] imem_addr,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_store,
  input  logic [1:0]  dmem_width,
  output logic        ihit,
  output logic [31:0] imem_load,
  output logic        dhit,
  output logic [31:0] dmem_load,
  output logic [31:0] ram_addr,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        misalign,
  output logic        bus_err
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DACC = 2'd1;
  localparam logic [1:0] IACC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       off, off_d;
  logic [1:0]       width, width_d;
  logic             is_store, is_store_d;
  logic             ihit_d, dhit_d, misalign_d, bus_err_d;
  logic             ram_ren_d, ram_wen_d;
  logic [31:0]      ram_addr_d, ram_wdata_d, imem_load_d, dmem_load_d;
  logic [3:0]       ram_be_d;

  logic             req_mis_c;
  logic [3:0]       req_be_c;
  logic [31:0]      rd_shift_c, rd_val_c;

  // Misalignment check and byte-enable mask for the incoming data request
  always_comb begin
    req_mis_c = 1'b0;
    req_be_c  = 4'b1111;
    case (dmem_width)
      2'b00: req_be_c = 4'b0001 << dmem_addr[1:0];
      2'b01: begin
        req_be_c  = 4'b0011 << dmem_addr[1:0];
        req_mis_c = dmem_addr[0];
      end
      default: req_mis_c = (dmem_addr[1:0] != 2'b00);
    endcase
  end

  // Right-align the addressed lanes of read data and zero-pad to the latched width
  always_comb begin
    rd_shift_c = ram_rdata >> {off, 3'b000};
    case (width)
      2'b00:   rd_val_c = {24'd0, rd_shift_c[7:0]};
      2'b01:   rd_val_c = {16'd0, rd_shift_c[15:0]};
      default: rd_val_c = rd_shift_c;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    off_d       = off;
    width_d     = width;
    is_store_d  = is_store;
    ihit_d      = 1'b0;
    dhit_d      = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    ram_ren_d   = ram_ren;
    ram_wen_d   = ram_wen;
    ram_addr_d  = ram_addr;
    ram_be_d    = ram_be;
    ram_wdata_d = ram_wdata;
    imem_load_d = imem_load;
    dmem_load_d = dmem_load;
    case (state)
      IDLE: begin
        if (dmem_ren || dmem_wen) begin
          if (req_mis_c) begin
            state_d     = DONE;
            dhit_d      = 1'b1;
            misalign_d  = 1'b1;
            dmem_load_d = 32'd0;
          end else begin
            state_d     = DACC;
            cnt_d       = '0;
            off_d       = dmem_addr[1:0];
            width_d     = dmem_width;
            is_store_d  = dmem_wen;
            ram_ren_d   = ~dmem_wen;
            ram_wen_d   = dmem_wen;
            ram_addr_d  = dmem_addr & 32'hFFFF_FFFC;
            ram_be_d    = req_be_c;
            ram_wdata_d = dmem_wen ? (dmem_store << {dmem_addr[1:0], 3'b000}) : 32'd0;
          end
        end else if (imem_ren) begin
          state_d     = IACC;
          cnt_d       = '0;
          ram_ren_d   = 1'b1;
          ram_wen_d   = 1'b0;
          ram_addr_d  = imem_addr & 32'hFFFF_FFFC;
          ram_be_d    = 4'b1111;
          ram_wdata_d = 32'd0;
        end
      end
      DACC, IACC: begin
        if (ram_ready || cnt == CNT_LAST) begin
          state_d   = DONE;
          cnt_d     = '0;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          bus_err_d = ~ram_ready;
          if (state == DACC) begin
            dhit_d      = 1'b1;
            dmem_load_d = (ram_ready && !is_store) ? rd_val_c : 32'd0;
          end else begin
            ihit_d      = 1'b1;
            imem_load_d = ram_ready ? ram_rdata : 32'd0;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      off       <= 2'd0;
      width     <= 2'd0;
      is_store  <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= 32'd0;
      ram_be    <= 4'd0;
      ram_wdata <= 32'd0;
      imem_load <= 32'd0;
      dmem_load <= 32'd0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      off       <= off_d;
      width     <= width_d;
      is_store  <= is_store_d;
      ihit      <= ihit_d;
      dhit      <= dhit_d;
      misalign  <= misalign_d;
      bus_err   <= bus_err_d;
      ram_ren   <= ram_ren_d;
      ram_wen   <= ram_wen_d;
      ram_addr  <= ram_addr_d;
      ram_be    <= ram_be_d;
      ram_wdata <= ram_wdata_d;
      imem_load <= imem_load_d;
      dmem_load <= dmem_load_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT_CYCLES = 4).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        imem_ren, dmem_ren, dmem_wen, ram_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_store, ram_rdata;
  logic [1:0]  dmem_width;
  logic        ihit, dhit, ram_ren, ram_wen, misalign, bus_err;
  logic [31:0] imem_load, dmem_load, ram_addr, ram_wdata;
  logic [3:0]  ram_be;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .nrst(nrst),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width),
    .ihit(ihit), .imem_load(imem_load), .dhit(dhit), .dmem_load(dmem_load),
    .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0; ram_ready = 1'b0;
    imem_addr = '0; dmem_addr = '0; dmem_store = '0; ram_rdata = '0; dmem_width = 2'b10;

    // reset state
    @(negedge clk);
    chk("rst_ram_ren", 32'(ram_ren), 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_hits", {30'd0, ihit, dhit}, 32'd0);
    chk("rst_flags", {30'd0, misalign, bus_err}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_be", 32'(ram_be), 32'd0);
    chk("rst_loads", imem_load | dmem_load | ram_wdata, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    // fetch at 0x100
    imem_ren = 1'b1; imem_addr = 32'h100;
    tick();
    chk("f_ram_ren", 32'(ram_ren), 32'd1);
    chk("f_ram_wen", 32'(ram_wen), 32'd0);
    chk("f_ram_addr", ram_addr, 32'h100);
    chk("f_ram_be", 32'(ram_be), 32'hF);
    chk("f_ihit_early", 32'(ihit), 32'd0);
    imem_ren = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h0050_0093;
    tick();
    ram_ready = 1'b0;
    chk("f_ihit", 32'(ihit), 32'd1);
    chk("f_imem_load", imem_load, 32'h0050_0093);
    chk("f_ren_done", 32'(ram_ren), 32'd0);
    tick();
    chk("f_ihit_after", 32'(ihit), 32'd0);
    chk("f_imem_hold", imem_load, 32'h0050_0093);

    // conflict: data word load at 0x204 wins over fetch at 0x300
    imem_ren = 1'b1; imem_addr = 32'h300;
    dmem_ren = 1'b1; dmem_addr = 32'h204; dmem_width = 2'b10;
    tick();
    chk("c_d_ren", 32'(ram_ren), 32'd1);
    chk("c_d_addr", ram_addr, 32'h204);
    chk("c_d_be", 32'(ram_be), 32'hF);
    dmem_ren = 1'b0; ram_ready = 1'b1; ram_rdata = 32'hCAFE_BABE;
    tick();
    ram_ready = 1'b0;
    chk("c_dhit", 32'(dhit), 32'd1);
    chk("c_ihit_none", 32'(ihit), 32'd0);
    chk("c_dmem_load", dmem_load, 32'hCAFE_BABE);
    chk("c_ren_gap", 32'(ram_ren), 32'd0);
    tick();
    chk("c_ren_idle", 32'(ram_ren), 32'd0);
    chk("c_dhit_after", 32'(dhit), 32'd0);
    tick();
    chk("c_i_ren", 32'(ram_ren), 32'd1);
    chk("c_i_addr", ram_addr, 32'h300);
    imem_ren = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h1234_5678;
    tick();
    ram_ready = 1'b0;
    chk("c_ihit", 32'(ihit), 32'd1);
    chk("c_imem_load", imem_load, 32'h1234_5678);
    chk("c_dhit_none", 32'(dhit), 32'd0);
    chk("c_dmem_hold", dmem_load, 32'hCAFE_BABE);
    tick();

    // sb 0xAB to 0x203
    dmem_wen = 1'b1; dmem_addr = 32'h203; dmem_width = 2'b00; dmem_store = 32'h0000_00AB;
    tick();
    chk("sb_wen", 32'(ram_wen), 32'd1);
    chk("sb_ren", 32'(ram_ren), 32'd0);
    chk("sb_addr", ram_addr, 32'h200);
    chk("sb_be", 32'(ram_be), 32'h8);
    chk("sb_wdata", ram_wdata, 32'hAB00_0000);
    dmem_wen = 1'b0; dmem_addr = 32'h0; ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    chk("sb_dhit", 32'(dhit), 32'd1);
    chk("sb_result", dmem_load, 32'd0);
    chk("sb_wen_done", 32'(ram_wen), 32'd0);
    tick();

    // sh 0xBEEF to 0x202
    dmem_wen = 1'b1; dmem_addr = 32'h202; dmem_width = 2'b01; dmem_store = 32'h0000_BEEF;
    tick();
    chk("sh_be", 32'(ram_be), 32'hC);
    chk("sh_wdata", ram_wdata, 32'hBEEF_0000);
    dmem_wen = 1'b0; ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    chk("sh_dhit", 32'(dhit), 32'd1);
    tick();

    // lbu at 0x202
    dmem_ren = 1'b1; dmem_addr = 32'h202; dmem_width = 2'b00;
    tick();
    chk("lbu_ren", 32'(ram_ren), 32'd1);
    chk("lbu_be", 32'(ram_be), 32'h4);
    dmem_ren = 1'b0; dmem_width = 2'b10; ram_ready = 1'b1; ram_rdata = 32'h1122_3344;
    tick();
    ram_ready = 1'b0;
    chk("lbu_dhit", 32'(dhit), 32'd1);
    chk("lbu_load", dmem_load, 32'h0000_0022);
    tick();
    chk("lbu_hold", dmem_load, 32'h0000_0022);

    // lhu at 0x202
    dmem_ren = 1'b1; dmem_addr = 32'h202; dmem_width = 2'b01;
    tick();
    chk("lhu_be", 32'(ram_be), 32'hC);
    dmem_ren = 1'b0; ram_ready = 1'b1; ram_rdata = 32'h1122_3344;
    tick();
    ram_ready = 1'b0;
    chk("lhu_load", dmem_load, 32'h0000_1122);
    tick();

    // misaligned lw at 0x206
    dmem_ren = 1'b1; dmem_addr = 32'h206; dmem_width = 2'b10;
    tick();
    dmem_ren = 1'b0;
    chk("mis_dhit", 32'(dhit), 32'd1);
    chk("mis_flag", 32'(misalign), 32'd1);
    chk("mis_load", dmem_load, 32'd0);
    chk("mis_no_strobe", {30'd0, ram_ren, ram_wen}, 32'd0);
    tick();
    chk("mis_flag_after", 32'(misalign), 32'd0);
    chk("mis_no_strobe2", {30'd0, ram_ren, ram_wen}, 32'd0);

    // timeout on fetch at 0x400
    imem_ren = 1'b1; imem_addr = 32'h400;
    tick();
    imem_ren = 1'b0;
    chk("to_ren_c1", 32'(ram_ren), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_ren_hold", 32'(ram_ren), 32'd1);
      chk("to_no_err", 32'(bus_err), 32'd0);
    end
    tick();
    chk("to_ren_drop", 32'(ram_ren), 32'd0);
    chk("to_bus_err", 32'(bus_err), 32'd1);
    chk("to_ihit", 32'(ihit), 32'd1);
    chk("to_imem_load", imem_load, 32'd0);
    tick();
    chk("to_bus_err_after", 32'(bus_err), 32'd0);

    // reset mid data access
    dmem_ren = 1'b1; dmem_addr = 32'h500; dmem_width = 2'b10;
    tick();
    chk("rm_ren", 32'(ram_ren), 32'd1);
    dmem_ren = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("rm_ren_async", 32'(ram_ren), 32'd0);
    chk("rm_addr_async", ram_addr, 32'd0);
    @(negedge clk);
    nrst = 1'b1; ram_ready = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rm_no_dhit", 32'(dhit), 32'd0);
    chk("rm_no_ren", 32'(ram_ren), 32'd0);
    ram_ready = 1'b0;

    // first request after reset release is sampled on the first edge
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1; imem_ren = 1'b1; imem_addr = 32'h600;
    tick();
    imem_ren = 1'b0;
    chk("pr_ren", 32'(ram_ren), 32'd1);
    chk("pr_addr", ram_addr, 32'h600);
    ram_ready = 1'b1; ram_rdata = 32'h0000_0013;
    tick();
    ram_ready = 1'b0;
    chk("pr_ihit", 32'(ihit), 32'd1);
    chk("pr_load", imem_load, 32'h0000_0013);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waited for ram_ready before abort (1..65535).
REQ-002 SHALL have ports, one per line:
- clk  in  1  rising-edge clock.
- nrst  in  1  reset, asynchronous, active-low.
- imem_ren  in  1  instruction fetch request.
- imem_addr  in  32  fetch byte address.
- dmem_ren  in  1  data load request.
- dmem_wen  in  1  data store request.
- dmem_addr  in  32  data byte address.
- dmem_store  in  32  store value, LSB-aligned.
- dmem_width  in  2  00 byte, 01 half, 10 word.
- ihit  out  1  fetch complete, one-cycle pulse.
- imem_load  out  32  fetched word, valid with ihit.
- dhit  out  1  data access complete, one-cycle pulse.
- dmem_load  out  32  load value, right-aligned and zero-padded, valid with dhit.
- ram_addr  out  32  word address to RAM, bits [1:0] = 00.
- ram_ren  out  1  RAM read strobe.
- ram_wen  out  1  RAM write strobe.
- ram_be  out  4  byte enables.
- ram_wdata  out  32  lane-shifted store data.
- ram_rdata  in  32  RAM read data, valid with ram_ready.
- ram_ready  in  1  RAM completes current access.
- misalign  out  1  one-cycle pulse, misaligned data access rejected.
- bus_err  out  1  one-cycle pulse, RAM timeout.

Function
REQ-003 SHALL implement FSM states IDLE, DACC, IACC, DONE.
REQ-004 SHALL, in IDLE, sample requests each cycle: dmem_ren or dmem_wen -> DACC; else imem_ren -> IACC; else stay IDLE.
REQ-005 SHALL give data priority on simultaneous requests; the fetch waits and is served after DONE.
REQ-006 SHALL treat dmem_ren and dmem_wen both high as a store.
REQ-007 SHALL latch address, store data, width and direction on the IDLE->DACC/IACC edge; input changes during DACC/IACC SHALL be ignored.
REQ-008 SHALL drive ram_ren/ram_wen from registers, high throughout DACC/IACC, low in all other states.
REQ-009 SHALL set ram_addr = {addr[31:2],2'b00}; IACC uses ram_be = 1111.
REQ-010 SHALL set ram_be on stores: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-011 SHALL set ram_wdata on stores = dmem_store << (8*addr[1:0]); loads set ram_be to the same mask as stores.
REQ-012 SHALL, on ram_ready in DACC/IACC, register the result and go to DONE. Load result = (ram_rdata >> 8*addr[1:0]) masked to width, upper bits zero. Store result = 0.
REQ-013 SHALL assert exactly one of ihit/dhit for the single DONE cycle, with imem_load/dmem_load valid in that cycle; DONE -> IDLE unconditionally, requests in DONE ignored.
REQ-014 SHALL yield minimum latency: request in cycle t, strobe in t+1, ram_ready in t+1 -> hit in t+2.
REQ-015 SHALL hold imem_load/dmem_load at their last values outside hits.
REQ-016 SHALL detect misalignment in IDLE (half with addr[0]=1; word with addr[1:0]!=00; width 11 treated as word): no RAM strobe, go directly to DONE with dhit, dmem_load=0, misalign pulsed in the DONE cycle.
REQ-017 SHALL count cycles in DACC/IACC; on reaching TIMEOUT_CYCLES without ram_ready, drop strobes, go to DONE, pulse the pending hit with load 0 and pulse bus_err.
REQ-018 SHALL ignore ram_ready outside DACC/IACC.

Reset
REQ-019 SHALL, on nrst low, immediately force IDLE. ihit, dhit, ram_ren, ram_wen, misalign, bus_err = 0; ram_addr, ram_be, ram_wdata, imem_load, dmem_load = 0; timeout counter = 0.
REQ-020 SHALL abandon any in-flight access on reset mid-operation, with no hit afterwards; the first request after nrst rises is sampled on the first rising edge.

Verification
REQ-021 Fetch: imem_ren=1, imem_addr=0x100, ram_ready in the first strobe cycle with rdata=0x00500093 -> ram_addr=0x100 ram_ren=1 at t+1, ihit=1 and imem_load=0x00500093 at t+2, then ihit=0.
REQ-022 Conflict: imem_ren and dmem_ren at t, dmem_addr=0x204 word -> DACC first and dhit; then IACC for the fetch and ihit; ram_ren never overlaps the two accesses.
REQ-023 Byte store and load: sb 0xAB to 0x203 -> ram_be=1000, ram_wdata=0xAB000000. lbu 0x202 with rdata=0x11223344 -> dmem_load=0x00000022.
REQ-024 Misaligned: lw at 0x206 -> no ram strobe, dhit and misalign both high one cycle after the request, dmem_load=0.
REQ-025 Timeout: TIMEOUT_CYCLES=4, ram_ready held 0 -> strobe high 4 cycles, then bus_err=1 with ihit=1 and imem_load=0.
REQ-026 Reset mid-access: nrst low during DACC -> ram_ren/ram_wen low asynchronously; no dhit after release.
